// File: rtl/arm_mem_pkg.sv
// Shared constants for the ARM data-memory bridge: MMIO register offsets
// and status-word bit positions.
package arm_mem_pkg;

    localparam logic [4:0] LED_OFS     = 5'h00;
    localparam logic [4:0] COUNT_OFS   = 5'h04;
    localparam logic [4:0] COMPARE_OFS = 5'h08;
    localparam logic [4:0] TSTAT_OFS   = 5'h0C;
    localparam logic [4:0] TXDATA_OFS  = 5'h10;
    localparam logic [4:0] TXSTAT_OFS  = 5'h14;

    localparam int TSTAT_MATCH_BIT  = 0;
    localparam int TSTAT_IRQEN_BIT  = 1;

    localparam int TXSTAT_EMPTY_BIT = 0;
    localparam int TXSTAT_FULL_BIT  = 1;
    localparam int TXSTAT_CNT_LSB   = 2;
    localparam int TXSTAT_OVF_BIT   = 5;

    function automatic logic [31:0] txstat_word(input logic ovf, input logic [2:0] cnt,
                                                input logic full, input logic empty);
        logic [31:0] w;
        w = '0;
        w[TXSTAT_OVF_BIT]                     = ovf;
        w[TXSTAT_CNT_LSB+2:TXSTAT_CNT_LSB]    = cnt;
        w[TXSTAT_FULL_BIT]                    = full;
        w[TXSTAT_EMPTY_BIT]                   = empty;
        return w;
    endfunction

    function automatic logic [31:0] tstat_word(input logic irq_en, input logic match);
        logic [31:0] w;
        w = '0;
        w[TSTAT_IRQEN_BIT] = irq_en;
        w[TSTAT_MATCH_BIT] = match;
        return w;
    endfunction

endpackage

// File: rtl/arm_tx_fifo.sv
// Circular byte FIFO feeding the UART drain port; head entry is presented
// combinationally and forced to zero while empty.
module arm_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/arm_dmem_bridge.sv
// Data-side memory for the ARM core's M stage: word RAM plus an MMIO page
// with LEDs, a compare timer and a TX byte FIFO. Reads are combinational.
module arm_dmem_bridge #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
    parameter int          TX_DEPTH  = 4,
    parameter string       MEMFILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  leds,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    import arm_mem_pkg::*;

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int FCW = $clog2(TX_DEPTH) + 1;

    logic [31:0]    ram [RAM_WORDS];
    logic [RAW-1:0] widx;
    logic           ram_hit, mmio_hit;
    logic [4:0]     ofs;
    logic           unused_lsbs;

    assign widx        = addr[RAW+1:2];
    assign ram_hit     = addr[31:2] < 30'(RAM_WORDS);
    assign mmio_hit    = (addr[31:5] == MMIO_BASE[31:5]);
    assign ofs         = {addr[4:2], 2'b00};
    assign unused_lsbs = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (we && ram_hit) ram[widx] <= wd;
    end

    logic mmio_wr;
    logic wr_led, wr_count, wr_cmp, wr_tstat, wr_txdata, wr_txstat;

    assign mmio_wr   = we & mmio_hit & ~ram_hit;
    assign wr_led    = mmio_wr & (ofs == LED_OFS);
    assign wr_count  = mmio_wr & (ofs == COUNT_OFS);
    assign wr_cmp    = mmio_wr & (ofs == COMPARE_OFS);
    assign wr_tstat  = mmio_wr & (ofs == TSTAT_OFS);
    assign wr_txdata = mmio_wr & (ofs == TXDATA_OFS);
    assign wr_txstat = mmio_wr & (ofs == TXSTAT_OFS);

    logic [7:0]     led_q;
    logic [31:0]    count_q, cmp_q;
    logic           match_q, irq_en_q, ovf_q;
    logic           fifo_full, fifo_empty, pop;
    logic [FCW-1:0] fifo_count;
    logic [2:0]     cnt3;

    assign pop  = tx_valid & tx_ready;
    assign cnt3 = 3'(fifo_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= '0;
            count_q  <= '0;
            cmp_q    <= 32'hFFFF_FFFF;
            match_q  <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_led) led_q <= wd[7:0];
            count_q <= wr_count ? wd : count_q + 32'd1;
            if (wr_cmp)   cmp_q    <= wd;
            if (wr_tstat) irq_en_q <= wd[TSTAT_IRQEN_BIT];
            // Match compares the pre-increment count; a set beats a W1C clear.
            if (count_q == cmp_q)
                match_q <= 1'b1;
            else if (wr_tstat && wd[TSTAT_MATCH_BIT])
                match_q <= 1'b0;
            if (wr_txdata && fifo_full && !pop)
                ovf_q <= 1'b1;
            else if (wr_txstat && wd[TXSTAT_OVF_BIT])
                ovf_q <= 1'b0;
        end
    end

    arm_tx_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .din   (wd[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_valid = ~fifo_empty;
    assign leds     = led_q;
    assign irq      = match_q & irq_en_q;

    always_comb begin
        rd = '0;
        if (ram_hit) begin
            rd = ram[widx];
        end else if (mmio_hit) begin
            case (ofs)
                LED_OFS:     rd = {24'h0, led_q};
                COUNT_OFS:   rd = count_q;
                COMPARE_OFS: rd = cmp_q;
                TSTAT_OFS:   rd = tstat_word(irq_en_q, match_q);
                TXSTAT_OFS:  rd = txstat_word(ovf_q, cnt3, fifo_full, fifo_empty);
                default:     rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_dmem_bridge.sv
// Bench for arm_dmem_bridge: directed vector table, hand sequences for the
// timer/FIFO corners, then random traffic against a queue-based model.
module tb_arm_dmem_bridge;

    localparam int          RAM_WORDS = 1024;
    localparam int          TX_DEPTH  = 4;
    localparam logic [31:0] MMIO      = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset, we, tx_ready;
    logic [31:0] addr, wd, rd;
    logic [7:0]  leds, tx_data;
    logic        irq, tx_valid;

    int checks = 0;
    int errors = 0;

    arm_dmem_bridge #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MMIO), .TX_DEPTH(TX_DEPTH), .MEMFILE("")) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wd(wd), .rd(rd), .leds(leds),
        .irq(irq), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_ram [int];
    logic [7:0]  m_leds;
    logic [31:0] m_count, m_cmp;
    bit          m_match, m_irqen, m_ovf;
    logic [7:0]  m_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_leds = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF;
        m_match = 0; m_irqen = 0; m_ovf = 0;
        m_q.delete();
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        int n;
        known = 1;
        n = m_q.size();
        if (a < 32'(4*RAM_WORDS)) begin
            if (m_ram.exists(int'(a[31:2]))) return m_ram[int'(a[31:2])];
            known = 0;
            return '0;
        end
        if (a >= MMIO && a < MMIO + 32'h20) begin
            case (a[4:2])
                3'd0: return {24'h0, m_leds};
                3'd1: return m_count;
                3'd2: return m_cmp;
                3'd3: return {30'h0, m_irqen, m_match};
                3'd5: return {26'h0, m_ovf, 3'(n), n == TX_DEPTH, n == 0};
                default: return '0;
            endcase
        end
        return '0;
    endfunction

    task automatic m_step();
        bit pop, push, set;
        logic [31:0] nxt;
        pop  = (m_q.size() != 0) && tx_ready;
        push = 0;
        set  = (m_count == m_cmp);
        nxt  = m_count + 32'd1;
        if (we) begin
            if (addr < 32'(4*RAM_WORDS)) m_ram[int'(addr[31:2])] = wd;
            else if (addr >= MMIO && addr < MMIO + 32'h20) begin
                case (addr[4:2])
                    3'd0: m_leds = wd[7:0];
                    3'd1: nxt = wd;
                    3'd2: m_cmp = wd;
                    3'd3: begin m_irqen = wd[1]; if (wd[0]) m_match = 0; end
                    3'd4: push = 1;
                    3'd5: if (wd[5]) m_ovf = 0;
                    default: ;
                endcase
            end
        end
        if (set) m_match = 1;
        m_count = nxt;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < TX_DEPTH) m_q.push_back(wd[7:0]);
            else m_ovf = 1;
        end
    endtask

    task automatic cmp_model();
        bit known;
        logic [31:0] e;
        e = m_read(addr, known);
        if (known) chk("model rd", rd, e);
        chk("model leds", 32'(leds), 32'(m_leds));
        chk("model irq", 32'(irq), 32'(m_match & m_irqen));
        chk("model tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        chk("model tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    endtask

    // Compare before the edge, advance model at the edge, return 1 after it.
    task automatic tick();
        #1;
        cmp_model();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1; addr = a; wd = d;
        tick();
        we = 0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic r, input logic c, input logic [31:0] er,
                                input logic [7:0] el, input logic ev, input logic [7:0] ed);
        vec_t v;
        v.we = w; v.addr = a; v.wd = d; v.rdy = r; v.chk_rd = c;
        v.exp_rd = er; v.exp_leds = el; v.exp_txv = ev; v.exp_txd = ed;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got [$];
        logic [7:0] want [4];
        bit found;
        logic [31:0] a, d;

        reset = 1; we = 0; addr = 0; wd = 0; tx_ready = 0;
        m_reset();

        addr = MMIO + 32'h08; #1 chk("reset compare", rd, 32'hFFFF_FFFF);
        addr = MMIO + 32'h04; #1 chk("reset count", rd, 32'h0);
        addr = MMIO + 32'h14; #1 chk("reset txstat", rd, 32'h1);
        addr = MMIO + 32'h0C; #1 chk("reset tstat", rd, 32'h0);
        chk("reset leds", 32'(leds), 32'h0);
        chk("reset tx_valid", 32'(tx_valid), 32'h0);
        chk("reset tx_data", 32'(tx_data), 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 0;

        // we addr wd rdy chk_rd exp_rd leds txv txd
        vecs.push_back(mk(1, 32'h10,   32'h0123_4567, 0, 0, 32'h0,         8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 32'h10,   32'hDEAD_BEEF, 0, 1, 32'h0123_4567, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 32'h10,   32'h0,         0, 1, 32'hDEAD_BEEF, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 32'h13,   32'h0,         0, 1, 32'hDEAD_BEEF, 8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 32'h2000, 32'h1234,      0, 1, 32'h0,         8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 32'h2000, 32'h0,         0, 1, 32'h0,         8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 32'h1018, 32'h0,         0, 1, 32'h0,         8'h00, 0, 8'h00));
        vecs.push_back(mk(1, 32'h1000, 32'hFFFF_FFA5, 0, 1, 32'h0,         8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 32'h1000, 32'h0,         0, 1, 32'hA5,        8'hA5, 0, 8'h00));
        vecs.push_back(mk(0, 32'h101C, 32'h0,         0, 1, 32'h0,         8'hA5, 0, 8'h00));
        vecs.push_back(mk(1, 32'h1010, 32'h11,        0, 1, 32'h0,         8'hA5, 0, 8'h00));
        vecs.push_back(mk(1, 32'h1010, 32'h22,        0, 1, 32'h0,         8'hA5, 1, 8'h11));
        vecs.push_back(mk(1, 32'h1010, 32'h33,        0, 1, 32'h0,         8'hA5, 1, 8'h11));
        vecs.push_back(mk(1, 32'h1010, 32'h44,        0, 1, 32'h0,         8'hA5, 1, 8'h11));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         0, 1, 32'h12,        8'hA5, 1, 8'h11));
        vecs.push_back(mk(1, 32'h1010, 32'h55,        0, 1, 32'h0,         8'hA5, 1, 8'h11));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         0, 1, 32'h32,        8'hA5, 1, 8'h11));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         1, 1, 32'h32,        8'hA5, 1, 8'h11));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         1, 1, 32'h2C,        8'hA5, 1, 8'h22));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         1, 1, 32'h28,        8'hA5, 1, 8'h33));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         1, 1, 32'h24,        8'hA5, 1, 8'h44));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         1, 1, 32'h21,        8'hA5, 0, 8'h00));
        vecs.push_back(mk(1, 32'h1014, 32'h20,        0, 1, 32'h21,        8'hA5, 0, 8'h00));
        vecs.push_back(mk(0, 32'h1014, 32'h0,         0, 1, 32'h01,        8'hA5, 0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            we = vecs[i].we; addr = vecs[i].addr; wd = vecs[i].wd; tx_ready = vecs[i].rdy;
            #1;
            if (vecs[i].chk_rd) chk($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].exp_leds));
            chk($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_txv));
            chk($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].exp_txd));
            tick();
        end
        we = 0; tx_ready = 0;

        // Timer: match at count==10, so irq is first seen with count already 11.
        wr(MMIO + 32'h04, 32'd5);
        wr(MMIO + 32'h08, 32'd10);
        wr(MMIO + 32'h0C, 32'h2);
        addr = MMIO + 32'h04;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (irq) begin found = 1; break; end
        end
        chk("timer irq rose", 32'(found), 32'h1);
        chk("timer count at irq", rd, 32'd11);
        wr(MMIO + 32'h0C, 32'h3);
        chk("timer irq cleared", 32'(irq), 32'h0);
        addr = MMIO + 32'h0C; #1;
        chk("timer tstat after clear", rd, 32'h2);
        wr(MMIO + 32'h04, 32'hFFFF_FFFF);
        addr = MMIO + 32'h04; #1;
        chk("count loaded", rd, 32'hFFFF_FFFF);
        tick();
        chk("count wrapped", rd, 32'h0);

        // Full FIFO accepts a push when popping in the same cycle.
        tx_ready = 0;
        wr(MMIO + 32'h10, 32'h11);
        wr(MMIO + 32'h10, 32'h22);
        wr(MMIO + 32'h10, 32'h33);
        wr(MMIO + 32'h10, 32'h44);
        tx_ready = 1;
        wr(MMIO + 32'h10, 32'h66);
        tx_ready = 0;
        addr = MMIO + 32'h14; #1;
        chk("push+pop full txstat", rd, 32'h12);
        tx_ready = 1;
        for (int i = 0; i < 10; i++) begin
            if (!tx_valid) break;
            got.push_back(tx_data);
            tick();
        end
        chk("drain length", 32'(got.size()), 32'd4);
        want[0] = 8'h22; want[1] = 8'h33; want[2] = 8'h44; want[3] = 8'h66;
        for (int i = 0; i < 4; i++)
            chk($sformatf("drain byte %0d", i), (i < got.size()) ? 32'(got[i]) : 32'hX, 32'(want[i]));

        // Asynchronous reset in the middle of a drain.
        tx_ready = 0;
        wr(MMIO + 32'h10, 32'hAA);
        wr(MMIO + 32'h10, 32'hBB);
        wr(MMIO + 32'h00, 32'h3C);
        tx_ready = 1;
        tick();
        chk("pre-reset tx_valid", 32'(tx_valid), 32'h1);
        #2 reset = 1;
        #1;
        chk("mid reset tx_valid", 32'(tx_valid), 32'h0);
        chk("mid reset tx_data", 32'(tx_data), 32'h0);
        chk("mid reset leds", 32'(leds), 32'h0);
        m_reset();
        #2 reset = 0;
        tx_ready = 0;
        addr = 32'h10; #1;
        chk("ram kept over reset", rd, 32'hDEAD_BEEF);
        addr = MMIO + 32'h14; #1;
        chk("txstat after reset", rd, 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                2:    a = MMIO + 32'($urandom_range(0, 31));
                default: a = $urandom_range(0, 1) ? 32'h2000 + 32'($urandom_range(0, 63)) : $urandom;
            endcase
            d = $urandom;
            if (a >= MMIO && a < MMIO + 32'h20 && a[4:2] == 3'd2)
                d = m_count + 32'($urandom_range(2, 10));
            we = ($urandom_range(0, 9) < 4);
            addr = a; wd = d;
            tx_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        we = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
